matrix_row_mem_seq: RTL and testbench

Sequencer placed directly upstream of the memory stage. It serialises one 128-bit matrix-row transfer into single-word data-memory accesses.
- Matrix row store: the row is split into 32-bit word writes.
- Matrix row load: 32-bit word reads are gathered back into a 128-bit row.
While a transfer is in progress it stalls the pipeline. It drives the word address, data and read/write enables consumed by the memory stage.

---
 rtl/matrix_row_mem_seq.sv | 104 ++++++++++
 tb/tb_matrix_row_mem_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_mem_seq.sv
// Serialises a 128-bit matrix-row store/load into single-word data-memory accesses,
// stalling the upstream pipeline from the accept cycle through the last word.
module matrix_row_mem_seq #(
  parameter int WORDS  = 4,
  parameter int STRIDE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [1:0]            len,
  input  logic [31:0]           base_addr,
  input  logic [32*WORDS-1:0]   row_wdata,
  input  logic                  flush,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic                  stall,
  output logic                  done,
  output logic [32*WORDS-1:0]   row_rdata,
  output logic                  err
);

  localparam int          DATA_W   = 32;
  localparam int          ROW_W    = DATA_W * WORDS;
  localparam logic [31:0] STRIDE_W = 32'(STRIDE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       idx_p0;
  logic             op_p0;
  logic [1:0]       len_p0;
  logic [31:0]      base_p0;
  logic [ROW_W-1:0] row_p0;
  logic             in_idle;
  logic             in_run;
  logic             req_ok;
  logic             accept;

  assign in_idle = (state == S_IDLE);
  assign in_run  = (state == S_RUN);
  assign req_ok  = in_idle && start && !flush;
  assign accept  = req_ok && (base_addr[1:0] == 2'b00);

  // Accept stage: request fields captured once, then held for the whole transfer
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= op;
      len_p0  <= len;
      base_p0 <= base_addr;
      row_p0  <= row_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx_p0    <= 2'd0;
      err       <= 1'b0;
      row_rdata <= '0;
    end else begin
      err <= req_ok && (base_addr[1:0] != 2'b00);
      // A read issued in a flushed cycle still lands, leaving partial row contents
      if (in_run && op_p0)
        row_rdata[idx_p0*DATA_W +: DATA_W] <= mem_rdata;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state  <= S_RUN;
              idx_p0 <= 2'd0;
              if (op)
                row_rdata <= '0;
            end
          end
          S_RUN: begin
            if (idx_p0 == len_p0)
              state <= S_DONE;
            else
              idx_p0 <= idx_p0 + 2'd1;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Access stage: memory-side signals are decoded straight from the current word slot
  assign mem_addr  = in_run ? (base_p0 + STRIDE_W * {30'd0, idx_p0}) : 32'd0;
  assign mem_wdata = (in_run && !op_p0) ? row_p0[idx_p0*DATA_W +: DATA_W] : 32'd0;
  assign mem_write = in_run && !op_p0;
  assign mem_read  = in_run && op_p0;
  assign stall     = in_run || accept;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_matrix_row_mem_seq.sv
// Directed bench for matrix_row_mem_seq: stores, loads, misalignment, flush, reset
// and held start, with hand-computed expectations and a tiny data-memory model.
`timescale 1ns/1ps
module tb_matrix_row_mem_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op;
  logic [1:0]   len;
  logic [31:0]  base_addr;
  logic [127:0] row_wdata;
  logic         flush;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_write;
  logic         mem_read;
  logic         stall;
  logic         done;
  logic [127:0] row_rdata;
  logic         err;

  int n_vec;
  int n_err;
  int wr_cnt;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];

  matrix_row_mem_seq #(.WORDS(4), .STRIDE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .len       (len),
    .base_addr (base_addr),
    .row_wdata (row_wdata),
    .flush     (flush),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .stall     (stall),
    .done      (done),
    .row_rdata (row_rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational data memory holding the load pattern
  always_comb begin
    case (mem_addr)
      32'h200: mem_rdata = 32'hAAAA0001;
      32'h204: mem_rdata = 32'hBBBB0002;
      32'h208: mem_rdata = 32'hCCCC0003;
      32'h20C: mem_rdata = 32'hDDDD0004;
      default: mem_rdata = 32'hDEADBEEF;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write && wr_cnt < 16) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; op = 1'b0; len = 2'd0; base_addr = 32'd0;
    row_wdata = '0; flush = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".stall"}, stall, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".err"}, err, 1'b0);
    chk({tag, ".mem_write"}, mem_write, 1'b0);
    chk({tag, ".mem_read"}, mem_read, 1'b0);
    chk({tag, ".mem_addr"}, mem_addr, 32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; wr_cnt = 0;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk_quiet("reset");
    chk("reset.row_rdata", row_rdata, 128'h0);

    // Four-word store
    tick();
    wr_cnt = 0;
    start = 1'b1; op = 1'b0; len = 2'd3; base_addr = 32'h100;
    row_wdata = 128'h44444444_33333333_22222222_11111111;
    settle();
    chk("st4.accept_stall", stall, 1'b1);
    chk("st4.accept_nowrite", mem_write, 1'b0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("st4.write", mem_write, 1'b1);
      chk("st4.read", mem_read, 1'b0);
      chk("st4.addr", mem_addr, 32'h100 + 32'(4 * i));
      chk("st4.wdata", mem_wdata, 32'h11111111 * 32'(i + 1));
      chk("st4.stall", stall, 1'b1);
      chk("st4.done_low", done, 1'b0);
      tick();
    end
    settle();
    chk("st4.done", done, 1'b1);
    chk("st4.done_stall", stall, 1'b0);
    chk("st4.done_write", mem_write, 1'b0);
    chk("st4.wr_cnt", wr_cnt, 4);
    tick();
    settle();
    chk_quiet("st4.after");

    // Four-word load fills every row word
    start = 1'b1; op = 1'b1; len = 2'd3; base_addr = 32'h200;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ld4.read", mem_read, 1'b1);
      chk("ld4.write", mem_write, 1'b0);
      chk("ld4.addr", mem_addr, 32'h200 + 32'(4 * i));
      tick();
    end
    settle();
    chk("ld4.done", done, 1'b1);
    chk("ld4.row", row_rdata, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    tick();

    // Two-word load must clear the upper row words
    start = 1'b1; op = 1'b1; len = 2'd1; base_addr = 32'h200;
    settle();
    chk("ld2.accept_stall", stall, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk("ld2.read0", mem_read, 1'b1);
    chk("ld2.addr0", mem_addr, 32'h200);
    tick();
    settle();
    chk("ld2.read1", mem_read, 1'b1);
    chk("ld2.addr1", mem_addr, 32'h204);
    tick();
    settle();
    chk("ld2.done", done, 1'b1);
    chk("ld2.read_off", mem_read, 1'b0);
    chk("ld2.row", row_rdata, 128'h00000000_00000000_BBBB0002_AAAA0001);
    tick();

    // Misaligned request
    wr_cnt = 0;
    start = 1'b1; op = 1'b0; len = 2'd3; base_addr = 32'h102;
    row_wdata = 128'h1;
    settle();
    chk("mis.stall", stall, 1'b0);
    chk("mis.write", mem_write, 1'b0);
    chk("mis.err_early", err, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("mis.err", err, 1'b1);
    chk("mis.write_after", mem_write, 1'b0);
    chk("mis.read_after", mem_read, 1'b0);
    chk("mis.stall_after", stall, 1'b0);
    tick();
    settle();
    chk("mis.err_pulse", err, 1'b0);
    chk("mis.wr_cnt", wr_cnt, 0);

    // Flush in the second RUN cycle of a store
    start = 1'b1; op = 1'b0; len = 2'd3; base_addr = 32'h100;
    row_wdata = 128'h44444444_33333333_22222222_11111111;
    tick();
    idle_inputs();
    tick();
    flush = 1'b1;
    settle();
    chk("fl.write1", mem_write, 1'b1);
    chk("fl.addr1", mem_addr, 32'h104);
    tick();
    flush = 1'b0;
    settle();
    chk("fl.write_off", mem_write, 1'b0);
    chk("fl.stall_off", stall, 1'b0);
    chk("fl.no_done", done, 1'b0);
    chk("fl.wr_cnt", wr_cnt, 2);
    chk("fl.wr_addr0", wr_addr[0], 32'h100);
    chk("fl.wr_data1", wr_data[1], 32'h22222222);
    start = 1'b1; op = 1'b1; len = 2'd0; base_addr = 32'h200;
    settle();
    chk("fl.reaccept", stall, 1'b1);
    tick();
    idle_inputs();
    settle();
    chk("fl.ld_read", mem_read, 1'b1);
    chk("fl.ld_addr", mem_addr, 32'h200);
    chk("fl.wr_cnt_hold", wr_cnt, 2);
    tick();
    settle();
    chk("fl.ld_done", done, 1'b1);
    chk("fl.ld_row", row_rdata, 128'h00000000_00000000_00000000_AAAA0001);
    tick();

    // Flush together with start in IDLE
    start = 1'b1; flush = 1'b1; op = 1'b0; len = 2'd0; base_addr = 32'h100;
    settle();
    chk("flst.stall", stall, 1'b0);
    tick();
    idle_inputs();
    settle();
    chk("flst.write", mem_write, 1'b0);

    // Reset in the middle of a load
    start = 1'b1; op = 1'b1; len = 2'd3; base_addr = 32'h200;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk_quiet("rst_mid");
    chk("rst_mid.row", row_rdata, 128'h0);
    start = 1'b1; op = 1'b1; len = 2'd0; base_addr = 32'h204;
    tick();
    idle_inputs();
    settle();
    chk("rst_ld.read", mem_read, 1'b1);
    chk("rst_ld.addr", mem_addr, 32'h204);
    tick();
    settle();
    chk("rst_ld.done", done, 1'b1);
    chk("rst_ld.row", row_rdata, 128'h00000000_00000000_00000000_BBBB0002);
    tick();

    // start held high across a two-word store
    wr_cnt = 0;
    start = 1'b1; op = 1'b0; len = 2'd1; base_addr = 32'h300;
    row_wdata = 128'h0_0_00000B0B_00000A0A;
    settle();
    chk("hold.accept1", stall, 1'b1);
    tick();
    settle();
    chk("hold.addr0", mem_addr, 32'h300);
    tick();
    settle();
    chk("hold.addr1", mem_addr, 32'h304);
    chk("hold.wdata1", mem_wdata, 32'h00000B0B);
    tick();
    settle();
    chk("hold.done", done, 1'b1);
    chk("hold.done_stall", stall, 1'b0);
    chk("hold.done_write", mem_write, 1'b0);
    chk("hold.wr_cnt1", wr_cnt, 2);
    tick();
    settle();
    chk("hold.accept2", stall, 1'b1);
    chk("hold.idle_write", mem_write, 1'b0);
    tick();
    start = 1'b0;
    settle();
    chk("hold.second_write", mem_write, 1'b1);
    chk("hold.second_addr", mem_addr, 32'h300);
    tick(); tick();
    settle();
    chk("hold.done2", done, 1'b1);
    chk("hold.wr_cnt2", wr_cnt, 4);
    tick();
    settle();
    chk_quiet("hold.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
